// File: rtl/modexp_io_port.sv
// modexp_io_port: word-serial operand/result port for the Montgomery modexp core.
// Operands are assembled least-significant word first into full-width registers.
// The block issues a single launch pulse to the core, captures the full-width
// result, and streams it back one word per cycle.
//
// Handshake: startInput and getResult are per-cycle level qualifiers, with no
// back-pressure. The port consumes one word set (load) or produces one word
// (output) on every rising edge where the qualifier is high in the state that
// accepts it. In every other state the qualifier is ignored. core_done is a
// one-cycle pulse, and core_result is valid in that cycle. res_valid marks
// res_out as a fresh word for exactly that cycle.
module modexp_io_port #(
    parameter int DATA_WIDTH = 64,
    parameter int WORDS      = 64,
    localparam int W         = DATA_WIDTH * WORDS,
    localparam int CW        = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startInput,
    input  logic [DATA_WIDTH-1:0] m_buf,
    input  logic [DATA_WIDTH-1:0] e_buf,
    input  logic [DATA_WIDTH-1:0] n_buf,
    input  logic [DATA_WIDTH-1:0] r_buf,
    input  logic [DATA_WIDTH-1:0] t_buf,
    input  logic [63:0]           nprime0,
    input  logic                  startCompute,
    input  logic                  getResult,
    output logic [W-1:0]          m_full,
    output logic [W-1:0]          e_full,
    output logic [W-1:0]          n_full,
    output logic [W-1:0]          r_full,
    output logic [W-1:0]          t_full,
    output logic [63:0]           nprime0_q,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [W-1:0]          core_result,
    output logic [DATA_WIDTH-1:0] res_out,
    output logic                  res_valid,
    output logic [2:0]            state,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_READY   = 3'd2,
        S_COMPUTE = 3'd3,
        S_HOLD    = 3'd4,
        S_OUTPUT  = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wr_idx;
    logic [W-1:0]  res_q;
    logic          cnt_last;
    logic          load_first;  // word 0 accepted from IDLE or DONE
    logic          load_word;   // subsequent word accepted in LOAD
    logic          launch;
    logic          capture;
    logic          emit;

    assign cnt_last = (cnt == CW'(WORDS - 1));
    assign wr_idx   = load_first ? '0 : cnt;
    assign state    = state_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_OUTPUT);

    // Next-state and per-cycle control strobes; events outside their state are dropped here.
    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        load_word  = 1'b0;
        launch     = 1'b0;
        capture    = 1'b0;
        emit       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (startInput) begin
                    load_first = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (startInput) begin
                    load_word = 1'b1;
                    if (cnt_last) state_d = S_READY;
                end
            end
            S_READY: begin
                // startCompute has priority; startInput is ignored here anyway.
                if (startCompute) begin
                    launch  = 1'b1;
                    state_d = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                if (core_done) begin
                    capture = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (getResult) state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (getResult) begin
                    emit = 1'b1;
                    if (cnt_last) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Shared word counter: counts load words, then output words; cleared at each terminal word.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load_first) begin
            cnt <= CW'(1);
        end else if (load_word || emit) begin
            cnt <= cnt_last ? '0 : cnt + 1'b1;
        end
    end

    // Operand assembly, launch pulse, result capture and registered result streaming.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_full     <= '0;
            e_full     <= '0;
            n_full     <= '0;
            r_full     <= '0;
            t_full     <= '0;
            nprime0_q  <= '0;
            res_q      <= '0;
            res_out    <= '0;
            res_valid  <= 1'b0;
            core_start <= 1'b0;
        end else begin
            if (load_first || load_word) begin
                m_full[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= m_buf;
                e_full[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= e_buf;
                n_full[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= n_buf;
                r_full[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= r_buf;
                t_full[wr_idx*DATA_WIDTH +: DATA_WIDTH] <= t_buf;
            end
            if (load_first) nprime0_q <= nprime0;
            core_start <= launch;
            if (capture) res_q <= core_result;
            res_valid <= emit;
            if (emit) res_out <= res_q[cnt*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_modexp_io_port.sv
// tb_modexp_io_port: directed bench for the modexp word-serial I/O port.
// A table of per-cycle control vectors covers the READY/COMPUTE/HOLD event handling.
// Hand-written sequences cover the loads, output streaming, stalls and mid-stream reset.
module tb_modexp_io_port;
    localparam int DW    = 64;
    localparam int WORDS = 64;
    localparam int W     = DW * WORDS;

    logic          clk = 1'b0;
    logic          reset;
    logic          startInput, startCompute, getResult, core_done;
    logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf;
    logic [63:0]   nprime0, nprime0_q;
    logic [W-1:0]  m_full, e_full, n_full, r_full, t_full, core_result;
    logic          core_start, res_valid, busy;
    logic [DW-1:0] res_out;
    logic [2:0]    state;

    int total = 0;
    int bad   = 0;

    logic [W-1:0]    em, ee, en, er, et, res_good;
    logic [DW-1:0]   exp_q[$];

    typedef struct {
        logic       si, sc, cd, gr, garbage;
        logic [2:0] exp_state;
        logic       exp_cs, exp_busy, exp_rv;
    } vec_t;
    vec_t vecs[8];

    modexp_io_port #(.DATA_WIDTH(DW), .WORDS(WORDS)) dut (
        .clk(clk), .reset(reset), .startInput(startInput),
        .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
        .nprime0(nprime0), .startCompute(startCompute), .getResult(getResult),
        .m_full(m_full), .e_full(e_full), .n_full(n_full), .r_full(r_full), .t_full(t_full),
        .nprime0_q(nprime0_q), .core_start(core_start), .core_done(core_done),
        .core_result(core_result), .res_out(res_out), .res_valid(res_valid),
        .state(state), .busy(busy)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_op(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            for (int k = 0; k < WORDS; k++) begin
                if (act[k*DW +: DW] !== exp[k*DW +: DW]) begin
                    $display("FAIL %s: word %0d got %h expected %h", name, k,
                             act[k*DW +: DW], exp[k*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 64'(state), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_core_start"}, 64'(core_start), 64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_res_out"}, res_out, 64'd0);
        chk({tag, "_nprime0_q"}, nprime0_q, 64'd0);
        chk_op({tag, "_m_full"}, m_full, '0);
        chk_op({tag, "_t_full"}, t_full, '0);
    endtask

    // Loads WORDS word sets; optional pause after one word and a stray startCompute at another.
    task automatic load_operands(input int seed, input int pause_after, input int compute_at);
        logic [63:0] m;
        for (int k = 0; k < WORDS; k++) begin
            m = (64'(seed) << 32) | 64'(k);
            m_buf = m;
            e_buf = {m[31:0], m[31:0]};
            n_buf = ~m;
            r_buf = m << 3;
            t_buf = m ^ 64'hF0F0_0000_0000_F0F0;
            nprime0 = (k == 0) ? 64'h1234 + 64'(seed) : 64'hDEAD_BEEF_0000_0000;
            em[k*DW +: DW] = m_buf;
            ee[k*DW +: DW] = e_buf;
            en[k*DW +: DW] = n_buf;
            er[k*DW +: DW] = r_buf;
            et[k*DW +: DW] = t_buf;
            startInput   = 1'b1;
            startCompute = (k == compute_at);
            tick();
            startCompute = 1'b0;
            if (k == compute_at) begin
                chk("load_sc_ignored_state", 64'(state), 64'd1);
                chk("load_sc_ignored_core_start", 64'(core_start), 64'd0);
            end
            if (k == WORDS - 2) chk("load_second_last_state", 64'(state), 64'd1);
            if (k == pause_after) begin
                startInput = 1'b0;
                m_buf = '1; e_buf = '1; n_buf = '1; r_buf = '1; t_buf = '1;
                repeat (5) begin
                    tick();
                    chk("load_pause_state", 64'(state), 64'd1);
                    chk("load_pause_busy", 64'(busy), 64'd1);
                end
            end
        end
        startInput = 1'b0;
        chk("load_done_state", 64'(state), 64'd2);
        chk("load_done_busy", 64'(busy), 64'd0);
        chk_op("m_full", m_full, em);
        chk_op("e_full", e_full, ee);
        chk_op("n_full", n_full, en);
        chk_op("r_full", r_full, er);
        chk_op("t_full", t_full, et);
        chk("nprime0_q", nprime0_q, 64'h1234 + 64'(seed));
    endtask

    task automatic set_result(input logic [63:0] base);
        for (int k = 0; k < WORDS; k++) res_good[k*DW +: DW] = base + 64'(k);
        core_result = res_good;
    endtask

    task automatic launch_and_capture(input logic [63:0] base);
        startCompute = 1'b1;
        tick();
        startCompute = 1'b0;
        chk("launch_core_start", 64'(core_start), 64'd1);
        chk("launch_state", 64'(state), 64'd3);
        set_result(base);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        core_result = '1;
        chk("launch_pulse_single", 64'(core_start), 64'd0);
        chk("capture_state", 64'(state), 64'd4);
    endtask

    // Streams the result; optional 3-cycle stall after one word, optional reset after another.
    task automatic read_result(input logic [63:0] base, input int stall_after, input int reset_at);
        logic [63:0] exp;
        for (int k = 0; k < WORDS; k++) exp_q.push_back(base + 64'(k));
        getResult = 1'b1;
        tick();
        chk("hold_to_output_state", 64'(state), 64'd5);
        chk("hold_to_output_no_valid", 64'(res_valid), 64'd0);
        for (int k = 0; k < WORDS; k++) begin
            getResult = 1'b1;
            tick();
            exp = exp_q.pop_front();
            chk($sformatf("out_valid_w%0d", k), 64'(res_valid), 64'd1);
            chk($sformatf("out_word_w%0d", k), res_out, exp);
            if (k == reset_at) begin
                getResult = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_reset_values("mid_output_reset");
                exp_q.delete();
                return;
            end
            if (k == stall_after) begin
                getResult = 1'b0;
                repeat (3) begin
                    tick();
                    chk("stall_no_valid", 64'(res_valid), 64'd0);
                    chk("stall_res_out_hold", res_out, exp);
                    chk("stall_state", 64'(state), 64'd5);
                end
            end
            if (k == WORDS - 2) chk("out_second_last_state", 64'(state), 64'd5);
        end
        chk("out_end_state", 64'(state), 64'd6);
        getResult = 1'b0;
        tick();
        chk("done_no_valid", 64'(res_valid), 64'd0);
        chk("done_state", 64'(state), 64'd6);
        chk("done_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        // si sc cd gr garbage | state cs busy rv
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0};

        reset = 1'b1;
        startInput = 1'b0; startCompute = 1'b0; getResult = 1'b0; core_done = 1'b0;
        m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0; nprime0 = '0;
        core_result = '0;
        res_good = '0;
        em = '0; ee = '0; en = '0; er = '0; et = '0;
        repeat (2) tick();
        reset = 1'b0;
        check_reset_values("por");

        // Paused load with a stray startCompute, then table-driven control events.
        load_operands(0, 10, 30);
        set_result(64'hA000);
        for (int i = 0; i < 8; i++) begin
            startInput   = vecs[i].si;
            startCompute = vecs[i].sc;
            core_done    = vecs[i].cd;
            getResult    = vecs[i].gr;
            core_result  = vecs[i].garbage ? ~res_good : res_good;
            tick();
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].exp_state));
            chk($sformatf("vec%0d_core_start", i), 64'(core_start), 64'(vecs[i].exp_cs));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_res_valid", i), 64'(res_valid), 64'(vecs[i].exp_rv));
        end
        startInput = 1'b0; startCompute = 1'b0; core_done = 1'b0; getResult = 1'b0;
        core_result = '1;
        read_result(64'hA000, 20, -1);

        // DONE keeps operands and ignores getResult.
        getResult = 1'b1;
        tick();
        getResult = 1'b0;
        chk("done_gr_ignored_state", 64'(state), 64'd6);
        chk("done_gr_ignored_valid", 64'(res_valid), 64'd0);
        chk_op("done_m_retained", m_full, em);

        // Reload from DONE, then reset in the middle of the output stream.
        load_operands(1, -1, -1);
        launch_and_capture(64'hB000);
        read_result(64'hB000, -1, 40);

        // A late core_done after reset is ignored.
        core_done = 1'b1;
        core_result = '1;
        tick();
        core_done = 1'b0;
        chk("late_core_done_state", 64'(state), 64'd0);
        chk("late_core_done_busy", 64'(busy), 64'd0);

        // Full clean cycle after reset.
        load_operands(2, -1, -1);
        launch_and_capture(64'hC000);
        read_result(64'hC000, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/modexp_io_port.md
# modexp_io_port

Word-serial operand/result port for the 4096-bit Montgomery modular-exponentiation datapath. It sits between the host-side word bus (64-bit `m_buf`/`e_buf`/`n_buf`/`r_buf`/`t_buf` plus `nprime0`) and the exponentiation core. It assembles the operands least-significant word first into full-width registers, issues a single start pulse to the core, captures the full-width result, and streams it back one word per cycle on `res_out`.

## Interface
- `DATA_WIDTH`, 64: bus word width in bits.
- `WORDS`, 64: words per operand; operand width W = DATA_WIDTH*WORDS = 4096.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `startInput` in 1: load qualifier; one word set is accepted per cycle while high.
- `m_buf`, `e_buf`, `n_buf`, `r_buf`, `t_buf` in DATA_WIDTH: operand words for message, exponent, modulus, R mod n, and R² mod n.
- `nprime0` in 64: −n⁻¹ mod 2^64; latched on the first accepted word.
- `startCompute` in 1: request to launch the core.
- `getResult` in 1: output qualifier; one word is emitted per cycle while high.
- `m_full`, `e_full`, `n_full`, `r_full`, `t_full` out W: assembled operands to the core.
- `nprime0_q` out 64: latched nprime0.
- `core_start` out 1: one-cycle launch pulse.
- `core_done` in 1: core completion pulse; `core_result` is valid in that cycle.
- `core_result` in W: full-width result from the core.
- `res_out` out DATA_WIDTH: result word.
- `res_valid` out 1: `res_out` carries a valid word this cycle.
- `state` out 3: current FSM state encoding.
- `busy` out 1: high in LOAD, COMPUTE, and OUTPUT.

## Operation
- States and encodings: IDLE=0, LOAD=1, READY=2, COMPUTE=3, HOLD=4, OUTPUT=5, DONE=6. The 6-bit word counter `cnt` is shared by load and output.
- IDLE:
  - If `startInput`=1, accept word 0, set `cnt`=1, and go to LOAD.
  - Words are written as `X_full[cnt*DATA_WIDTH +: DATA_WIDTH]` <= `X_buf` for all five operands in the same cycle.
- LOAD:
  - Each cycle with `startInput`=1, write word `cnt` and increment `cnt`.
  - `startInput`=0 pauses the load; `cnt` and the registers hold.
  - On acceptance of word WORDS−1, go to READY and clear `cnt`.
- READY: when `startCompute`=1, pulse `core_start` for exactly one cycle and go to COMPUTE.
- COMPUTE: on `core_done`=1, latch `core_result` into the internal register `res_q` and go to HOLD.
- HOLD: when `getResult`=1, go to OUTPUT.
- OUTPUT:
  - Each cycle with `getResult`=1, drive `res_out`=`res_q[cnt*DATA_WIDTH +: DATA_WIDTH]` with `res_valid`=1, then increment `cnt`.
  - `getResult`=0 stalls: `res_valid`=0, `cnt` holds, and `res_out` holds its last value.
  - After word WORDS−1, go to DONE.
- DONE:
  - Operands and `res_q` are retained.
  - `startInput`=1 starts a new load exactly as from IDLE; all registers are overwritten word by word.
- Ignored events (no state change, no side effect):
  - `startCompute` outside READY, including during LOAD before all words are in.
  - `core_done` outside COMPUTE.
  - `startInput` in READY, COMPUTE, HOLD, or OUTPUT.
  - `getResult` outside HOLD and OUTPUT.
- Simultaneous `startInput` and `startCompute` in READY: `startCompute` wins.
- No arithmetic beyond the counter increment; `cnt` never wraps within a phase because the terminal compare is at WORDS−1.

## Timing
- Reset values:
  - `state`=IDLE, `cnt`=0.
  - All `*_full`, `nprime0_q`, `res_q`, and `res_out` are 0.
  - `core_start`=0, `res_valid`=0, `busy`=0.
- Reset asserted mid-load, mid-compute, or mid-output returns the block to the reset values on the next edge. A `core_done` arriving after reset is ignored.
- Load latency: WORDS cycles of `startInput` from the IDLE accept edge to READY, so 64 cycles unpaused.
- `core_start` is registered: it is high in the cycle after `startCompute` is sampled in READY.
- `res_out`/`res_valid` are registered: the first word appears in the second cycle after `getResult` is sampled in HOLD.
- With `getResult` held high, the output streams WORDS consecutive valid cycles.
- Operand outputs are stable from READY until the next load begins.

## Test plan
- Load 64 words with word k = {k, k}, using m_buf=k, n_buf=~k, and nprime0=64'h1234 on word 0 → after 64 cycles state=READY, `m_full[64k+:64]`=k for all k, `nprime0_q`=64'h1234.
- Pause `startInput` for 5 cycles after word 10 → cnt holds at 11, and the final operands are identical to the unpaused load.
- Assert `startCompute` at word 30 of a load → ignored. In READY, assert `startCompute` → exactly one `core_start` pulse, state=COMPUTE.
- Drive `core_done` with `core_result` having word k = 64'hA000+k, then `getResult` continuously → 64 consecutive `res_valid` cycles, `res_out`=64'hA000..64'hA03F in order, state=DONE.
- Drop `getResult` for 3 cycles after word 20 of output → `res_valid`=0 and `res_out` holds. Output resumes with word 21, with no word lost or duplicated.
- Assert `reset` at output word 40 → next cycle state=IDLE and all outputs are zero. A subsequent full load/compute/read cycle completes correctly.
